// File: rtl/io64_uart_tx.sv
// io64_uart_tx: CPU15 output port at address 64. Buffers 16-bit words in a FIFO and sends each
// word as two UART frames, low byte first. Define UART_PARITY_EN to add an even-parity bit per frame.
module io64_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_EN,
  input  logic [15:0] WR_DATA,
  input  logic        OVF_CLR,
  output logic        TX,
  output logic        FULL,
  output logic        EMPTY,
  output logic [15:0] STATUS
);
  localparam int          AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [3:0]  DEPTH  = 4'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;
  logic          ovf;
  logic          push, pop, busy;

  state_t        state, state_n;
  logic [15:0]   baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic          hi, hi_n;
  logic [15:0]   word_q, word_n;
  logic          tx_q, tx_n;
  logic [7:0]    cur_byte;

  assign FULL   = (count == DEPTH);
  assign EMPTY  = (count == 4'd0);
  assign busy   = (state != IDLE);
  assign push   = WR_EN && !FULL;
  assign TX     = tx_q;
  assign STATUS = {8'h00, count, ovf, busy, FULL, EMPTY};

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;
      // A dropped write outranks a clear on the same edge
      if (WR_EN && FULL)  ovf <= 1'b1;
      else if (OVF_CLR)   ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      hi      <= 1'b0;
      word_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      hi      <= hi_n;
      word_q  <= word_n;
      tx_q    <= tx_n;
    end
  end

  assign cur_byte = hi ? word_q[15:8] : word_q[7:0];

  // tx_n is the line level for the state being entered, so TX stays a clean register output
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    hi_n    = hi;
    word_n  = word_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!EMPTY) begin
          pop     = 1'b1;
          word_n  = mem[rd_ptr];
          hi_n    = 1'b0;
          state_n = START;
          baud_n  = DIV_M1;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud == 16'd0) begin
          state_n = DATA;
          baud_n  = DIV_M1;
          bit_n   = 3'd0;
          tx_n    = cur_byte[0];
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == 16'd0) begin
          baud_n = DIV_M1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
            tx_n    = ^cur_byte;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = cur_byte[bit_n];
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud == 16'd0) begin
          state_n = STOP;
          baud_n  = DIV_M1;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
`endif
      STOP: begin
        if (baud == 16'd0) begin
          if (!hi) begin
            hi_n    = 1'b1;
            state_n = START;
            baud_n  = DIV_M1;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_io64_uart_tx.sv
// Testbench for io64_uart_tx: logs the TX line every cycle and compares it with the waveform
// expected from the word list and the framing rules.
module tb_io64_uart_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WORD_CYC = 2 * FRAME_BITS * CLK_DIV;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WR_EN = 1'b0;
  logic [15:0] WR_DATA = '0;
  logic        OVF_CLR = 1'b0;
  logic        TX, FULL, EMPTY;
  logic [15:0] STATUS;

  int checks = 0;
  int failures = 0;

  logic        log_en = 1'b0;
  logic        tx_log[$];
  logic        exp_q[$];
  logic [15:0] words[$];

  io64_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .OVF_CLR(OVF_CLR),
    .TX(TX), .FULL(FULL), .EMPTY(EMPTY), .STATUS(STATUS)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (log_en) tx_log.push_back(TX);

  // Expected line: each word is two frames, followed by one idle-high cycle.
  function automatic void build_expected();
    logic [7:0] b;
    exp_q.delete();
    foreach (words[w]) begin
      for (int h = 0; h < 2; h++) begin
        b = (h == 0) ? words[w][7:0] : words[w][15:8];
        for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(b[i]);
`ifdef UART_PARITY_EN
        for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(^b);
`endif
        for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(1'b1);
      end
      exp_q.push_back(1'b1);
    end
  endfunction

  function automatic int first_low();
    foreach (tx_log[i]) if (tx_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int stream_errors(int first);
    int e = 0;
    if (first < 0) return exp_q.size();
    foreach (exp_q[i])
      if (first + i >= tx_log.size() || tx_log[first + i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic logic [7:0] decode_byte(int start);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b[i] = tx_log[start + CLK_DIV * (1 + i) + CLK_DIV / 2];
    return b;
  endfunction

  task automatic do_reset();
    RESET = 1'b1; WR_EN = 1'b0; OVF_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  // Log entry 0 is the cycle before the write edge, so the start bit should appear at entry 2.
  task automatic write_one_logged(input logic [15:0] w);
    @(posedge CLK);
    tx_log.delete();
    log_en = 1'b1;
    @(negedge CLK);
    WR_EN = 1'b1; WR_DATA = w;
    @(negedge CLK);
    WR_EN = 1'b0;
    repeat (WORD_CYC + 4) @(negedge CLK);
    log_en = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", TX); end
    checks++;
    if (STATUS !== 16'h0001) begin failures++; $display("FAIL reset_status: got %h expected 0001", STATUS); end
    checks++;
    if (FULL !== 1'b0 || EMPTY !== 1'b1) begin
      failures++; $display("FAIL reset_flags: got full=%b empty=%b expected 0/1", FULL, EMPTY);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int fl, e;
    words.delete(); words.push_back(16'hA55A);
    write_one_logged(16'hA55A);
    build_expected();
    fl = first_low();
    checks++;
    if (fl !== 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", fl); end
    checks++;
    if (fl >= 0 && decode_byte(fl) !== 8'h5A) begin
      failures++; $display("FAIL single_low_byte: got %h expected 5a", decode_byte(fl));
    end
    checks++;
    if (fl >= 0 && decode_byte(fl + FRAME_BITS * CLK_DIV) !== 8'hA5) begin
      failures++; $display("FAIL single_high_byte: got %h expected a5", decode_byte(fl + FRAME_BITS * CLK_DIV));
    end
    e = stream_errors(fl);
    checks++;
    if (e != 0) begin failures++; $display("FAIL single_stream: got %0d bad samples expected 0", e); end
    checks++;
    if (STATUS !== 16'h0001) begin failures++; $display("FAIL single_idle_status: got %h expected 0001", STATUS); end
  endtask

  task automatic test_parity();
    int e;
    words.delete(); words.push_back(16'h0703);
    write_one_logged(16'h0703);
    build_expected();
    e = stream_errors(first_low());
    checks++;
    if (e != 0) begin failures++; $display("FAIL parity_stream: got %0d bad samples expected 0", e); end
    // Slot after the 8th data bit: parity (0 for 0x03) when enabled, otherwise the stop bit
    checks++;
`ifdef UART_PARITY_EN
    if (tx_log[2 + 9 * CLK_DIV + 1] !== 1'b0) begin
      failures++; $display("FAIL parity_byte0: got %b expected 0", tx_log[2 + 9 * CLK_DIV + 1]);
    end
    checks++;
    if (tx_log[2 + (FRAME_BITS + 9) * CLK_DIV + 1] !== 1'b1) begin
      failures++; $display("FAIL parity_byte1: got %b expected 1", tx_log[2 + (FRAME_BITS + 9) * CLK_DIV + 1]);
    end
`else
    if (tx_log[2 + 9 * CLK_DIV + 1] !== 1'b1) begin
      failures++; $display("FAIL stop_after_data: got %b expected 1", tx_log[2 + 9 * CLK_DIV + 1]);
    end
`endif
    checks++;
    if (tx_log[2 + WORD_CYC - 1] !== 1'b1 || tx_log[2 + WORD_CYC - CLK_DIV - 1] === 1'bx) begin
      failures++; $display("FAIL word_length: got %b expected 1", tx_log[2 + WORD_CYC - 1]);
    end
  endtask

  task automatic test_wrap();
    int e;
    logic [15:0] w;
    for (int i = 0; i < 20; i++) begin
      w = (16'($urandom) & 16'hFFE0) | 16'(i);
      words.delete(); words.push_back(w);
      write_one_logged(w);
      build_expected();
      e = stream_errors(first_low());
      checks++;
      if (e != 0) begin failures++; $display("FAIL wrap_word%0d: got %0d bad samples expected 0 (word %h)", i, e, w); end
    end
    checks++;
    if (EMPTY !== 1'b1 || STATUS[7:4] !== 4'd0) begin
      failures++; $display("FAIL wrap_end: got empty=%b count=%0d expected 1/0", EMPTY, STATUS[7:4]);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d[10];
    int e, fl;
    do_reset();
    words.delete();
    for (int k = 0; k < 10; k++) begin
      d[k] = 16'($urandom);
      if (k < 9) words.push_back(d[k]);
    end
    @(posedge CLK);
    tx_log.delete();
    log_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (k == 9) begin
        checks++;
        if (STATUS !== 16'h0086) begin failures++; $display("FAIL ovf_full_status: got %h expected 0086", STATUS); end
      end
      WR_EN = 1'b1; WR_DATA = d[k];
    end
    @(negedge CLK);
    WR_EN = 1'b0;
    checks++;
    if (STATUS !== 16'h008E || FULL !== 1'b1) begin
      failures++; $display("FAIL ovf_set: got %h full=%b expected 008e full=1", STATUS, FULL);
    end
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    checks++;
    if (STATUS !== 16'h0086) begin failures++; $display("FAIL ovf_clear: got %h expected 0086", STATUS); end
    WR_EN = 1'b1; OVF_CLR = 1'b1; WR_DATA = 16'hDEAD;
    @(negedge CLK);
    WR_EN = 1'b0; OVF_CLR = 1'b0;
    checks++;
    if (STATUS !== 16'h008E) begin failures++; $display("FAIL ovf_beats_clr: got %h expected 008e", STATUS); end
    OVF_CLR = 1'b1;
    @(negedge CLK);
    OVF_CLR = 1'b0;
    checks++;
    if (STATUS[3] !== 1'b0) begin failures++; $display("FAIL ovf_clear2: got %b expected 0", STATUS[3]); end
    repeat (9 * (WORD_CYC + 1) + 10) @(negedge CLK);
    log_en = 1'b0;
    build_expected();
    fl = first_low();
    checks++;
    if (fl !== 2) begin failures++; $display("FAIL ovf_first_start: got %0d expected 2", fl); end
    e = stream_errors(fl);
    checks++;
    if (e != 0) begin failures++; $display("FAIL ovf_drain_stream: got %0d bad samples expected 0", e); end
    checks++;
    if (STATUS !== 16'h0001) begin failures++; $display("FAIL ovf_drained: got %h expected 0001", STATUS); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] a, b, c;
    int e, fl;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    words.delete(); words.push_back(a); words.push_back(b); words.push_back(c);
    @(posedge CLK);
    tx_log.delete();
    log_en = 1'b1;
    @(negedge CLK);
    WR_EN = 1'b1; WR_DATA = a;
    @(negedge CLK);
    WR_DATA = b;
    @(negedge CLK);
    WR_EN = 1'b0;
    checks++;
    if (STATUS[7:4] !== 4'd1) begin failures++; $display("FAIL simul_first_count: got %0d expected 1", STATUS[7:4]); end
    repeat (WORD_CYC) @(negedge CLK);
    checks++;
    if (STATUS !== 16'h0010) begin failures++; $display("FAIL simul_idle: got %h expected 0010", STATUS); end
    WR_EN = 1'b1; WR_DATA = c;
    @(negedge CLK);
    WR_EN = 1'b0;
    checks++;
    if (STATUS !== 16'h0014) begin failures++; $display("FAIL simul_count: got %h expected 0014", STATUS); end
    repeat (2 * (WORD_CYC + 1) + 8) @(negedge CLK);
    log_en = 1'b0;
    build_expected();
    fl = first_low();
    e = stream_errors(fl);
    checks++;
    if (fl !== 2 || e != 0) begin
      failures++; $display("FAIL simul_stream: got start=%0d bad=%0d expected start=2 bad=0", fl, e);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w, w2;
    int e, fl;
    w = 16'($urandom) & 16'hF7FF;
    @(negedge CLK);
    WR_EN = 1'b1; WR_DATA = w;
    @(negedge CLK);
    WR_EN = 1'b0;
    repeat (FRAME_BITS * CLK_DIV + 4 * CLK_DIV + 2) @(negedge CLK);
    checks++;
    if (TX !== 1'b0) begin failures++; $display("FAIL midframe_bit3: got %b expected 0", TX); end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (TX !== 1'b1 || STATUS !== 16'h0001) begin
      failures++; $display("FAIL midframe_reset: got tx=%b status=%h expected 1/0001", TX, STATUS);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    w2 = 16'($urandom);
    words.delete(); words.push_back(w2);
    write_one_logged(w2);
    build_expected();
    fl = first_low();
    e = stream_errors(fl);
    checks++;
    if (fl !== 2 || e != 0) begin
      failures++; $display("FAIL midframe_fresh: got start=%0d bad=%0d expected start=2 bad=0", fl, e);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_wrap();
    test_overflow();
    test_simultaneous();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
